jesd204b_lmfc_sysref_tracker: RTL and testbench

JESD204B_LMFC_SYSREF_TRACKER -- requirements
Module: jesd204b_lmfc_sysref_tracker

---
 rtl/jesd204b_lmfc_sysref_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_jesd204b_lmfc_sysref_tracker.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_lmfc_sysref_tracker.sv
`default_nettype none
// ============================================================================
// Module   : jesd204b_lmfc_sysref_tracker
// Purpose  : Generates the JESD204B local multiframe clock (LMFC) phase in the
//            dclk domain. The phase is aligned to SYSREF rising edges according
//            to cfg_mode, and out-of-phase SYSREF edges are counted.
// Ports    : dclk, rst_n            - device clock, async active-low reset
//            sysref                 - SYSREF level from the pin
//            cfg_mode[1:0]          - 0 off, 1 one-shot, 2 continuous, 3 monitor
//            cfg_arm, err_clr       - one-cycle control pulses
//            o_lmfc                 - LMFC boundary pulse
//            o_lmfc_phase[PH_W-1:0] - dclk position inside the multiframe
//            o_mf_cnt               - wrapping multiframe counter
//            o_aligned              - phase has been set by a SYSREF edge
//            o_sysref_err, o_err_cnt- sticky error flag / saturating count
// Macro    : JESD_SYSREF_SYNC_EN - adds a two-flop synchronizer ahead of the
//            SYSREF sample flop (+2 dclk detection latency).
// Revision : 1.0 - initial release
// ============================================================================
module jesd204b_lmfc_sysref_tracker #(
  parameter  int JESD_F       = 2,
  parameter  int JESD_K       = 32,
  parameter  int DCLK_DIV     = 4,
  parameter  int MF_CNT_WIDTH = 8,
  localparam int P            = JESD_F * JESD_K / DCLK_DIV,
  localparam int PH_W         = $clog2(P)
) (
  input  logic                    dclk,
  input  logic                    rst_n,
  input  logic                    sysref,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_arm,
  input  logic                    err_clr,
  output logic                    o_lmfc,
  output logic [PH_W-1:0]         o_lmfc_phase,
  output logic [MF_CNT_WIDTH-1:0] o_mf_cnt,
  output logic                    o_aligned,
  output logic                    o_sysref_err,
  output logic [7:0]              o_err_cnt
);

  generate
    if (((JESD_F * JESD_K) % DCLK_DIV) != 0 || P < 2) begin : g_bad_p
      $error("JESD_F*JESD_K/DCLK_DIV must be an integer >= 2");
    end
  endgenerate

  localparam logic [1:0]      ST_IDLE      = 2'd0;
  localparam logic [1:0]      ST_ARMED     = 2'd1;
  localparam logic [1:0]      ST_LOCKED    = 2'd2;
  localparam logic [1:0]      MODE_OFF     = 2'd0;
  localparam logic [1:0]      MODE_ONESHOT = 2'd1;
  localparam logic [1:0]      MODE_CONT    = 2'd2;
  localparam logic [PH_W-1:0] PH_LAST      = PH_W'(P - 1);

  // --------------------------------------------------------------------------
  // SYSREF front end
  // --------------------------------------------------------------------------
  logic sysref_in;

`ifdef JESD_SYSREF_SYNC_EN
  localparam int FILL_W = 4;
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], sysref};

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sysref_in = sync_q[1];
`else
  localparam int FILL_W = 2;
  assign sysref_in = sysref;
`endif

  logic              sample_q, sample_d;
  logic              prev_q, prev_d;
  // Fill marker: the edge detector is only trusted once every stage between
  // the pin and prev_q holds a real post-reset sample. Otherwise SYSREF held
  // high through reset would look like a rising edge against the reset zeros.
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              edge_det;

  always_comb begin
    sample_d = sysref_in;
    prev_d   = sample_q;
    fill_d   = {fill_q[FILL_W-2:0], 1'b1};
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
      fill_q   <= '0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      fill_q   <= fill_d;
    end
  end

  assign edge_det = sample_q & ~prev_q & fill_q[FILL_W-1];

  // --------------------------------------------------------------------------
  // Capture state machine
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       capture;   // first alignment from ARMED
  logic       reload;    // continuous-mode realignment while LOCKED

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_mode == MODE_OFF) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_ARMED;
        ST_ARMED:  if (edge_det) state_d = ST_LOCKED;
        // An edge coinciding with cfg_arm is not consumed: we go back to
        // ARMED and wait for the next edge.
        ST_LOCKED: if (cfg_mode == MODE_ONESHOT && cfg_arm) state_d = ST_ARMED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    capture = (state_q == ST_ARMED) && (cfg_mode != MODE_OFF) && edge_det;
    reload  = (state_q == ST_LOCKED) && (cfg_mode == MODE_CONT) && edge_det;
  end

  // --------------------------------------------------------------------------
  // Phase / multiframe counters, alignment and error tracking
  // --------------------------------------------------------------------------
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [MF_CNT_WIDTH-1:0] mf_cnt_q, mf_cnt_d;
  logic                    aligned_q, aligned_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    out_of_phase;

  always_comb begin
    out_of_phase = edge_det && aligned_q && (cfg_mode != MODE_OFF) &&
                   (phase_q != PH_LAST);

    if (phase_q == PH_LAST) begin
      phase_d  = '0;
      mf_cnt_d = mf_cnt_q + MF_CNT_WIDTH'(1);
    end else begin
      phase_d  = phase_q + PH_W'(1);
      mf_cnt_d = mf_cnt_q;
    end

    if (capture) begin
      phase_d  = '0;
      mf_cnt_d = '0;
    end else if (reload) begin
      // A continuous-mode reload starts a new multiframe, so the count
      // advances exactly as on a natural wrap; an in-phase edge is invisible.
      phase_d  = '0;
      mf_cnt_d = mf_cnt_q + MF_CNT_WIDTH'(1);
    end

    aligned_d = aligned_q;
    if (cfg_mode == MODE_OFF) aligned_d = 1'b0;
    else if (capture)         aligned_d = 1'b1;

    // Clear first, then count, so a clear coinciding with an error leaves 1.
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
    if (out_of_phase) begin
      err_d = 1'b1;
      if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      mf_cnt_q  <= '0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      phase_q   <= phase_d;
      mf_cnt_q  <= mf_cnt_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_lmfc       = (phase_q == '0) && aligned_q;
  assign o_lmfc_phase = phase_q;
  assign o_mf_cnt     = mf_cnt_q;
  assign o_aligned    = aligned_q;
  assign o_sysref_err = err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_lmfc_sysref_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd204b_lmfc_sysref_tracker
// Purpose  : Self-checking bench for jesd204b_lmfc_sysref_tracker (P = 16).
//            A cycle reference model computes phase and multiframe count
//            arithmetically from the cycle of the last phase load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204b_lmfc_sysref_tracker;

  localparam int P = 16;
`ifdef JESD_SYSREF_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int LAT = S + 2;

  logic       dclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sysref = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       cfg_arm = 1'b0;
  logic       err_clr = 1'b0;
  logic       o_lmfc;
  logic [3:0] o_lmfc_phase;
  logic [7:0] o_mf_cnt;
  logic       o_aligned;
  logic       o_sysref_err;
  logic [7:0] o_err_cnt;

  jesd204b_lmfc_sysref_tracker dut (
    .dclk         (dclk),
    .rst_n        (rst_n),
    .sysref       (sysref),
    .cfg_mode     (cfg_mode),
    .cfg_arm      (cfg_arm),
    .err_clr      (err_clr),
    .o_lmfc       (o_lmfc),
    .o_lmfc_phase (o_lmfc_phase),
    .o_mf_cnt     (o_mf_cnt),
    .o_aligned    (o_aligned),
    .o_sysref_err (o_sysref_err),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int errors = 0;

  logic [22:0] act_vec;
  assign act_vec = {o_lmfc, o_aligned, o_sysref_err, o_lmfc_phase, o_mf_cnt, o_err_cnt};

  // ---------------- reference model ----------------
  int k;          // posedges since reset release
  bit raw[$];     // raw[j] = sysref level at posedge j
  int load_k;     // posedge at which the phase was last forced to 0
  int mf_base;    // multiframe count at load_k
  bit m_al, m_err;
  int m_cnt;
  int m_stage;    // 0 off, 1 waiting for an edge, 2 locked
  int oop_total;

  function automatic int m_phase();
    return (k - load_k) % P;
  endfunction

  function automatic int m_mf();
    return (mf_base + (k - load_k) / P) % 256;
  endfunction

  function automatic bit s_at(int j);
    return (j - S >= 1) ? raw[j - S] : 1'b0;
  endfunction

  // Rising edge visible in the cycle following posedge k.
  function automatic bit m_edge();
    return (k >= S + 2) && s_at(k) && !s_at(k - 1);
  endfunction

  function automatic logic [22:0] exp_vec();
    return {(m_phase() == 0) && m_al, m_al, m_err, 4'(m_phase()), 8'(m_mf()), 8'(m_cnt)};
  endfunction

  task automatic model_reset();
    k = 0; raw.delete(); raw.push_back(1'b0);
    load_k = 0; mf_base = 0; m_al = 0; m_err = 0; m_cnt = 0; m_stage = 0;
  endtask

  task automatic tick();
    bit e; int ph, mfv; bit oop;
    e = m_edge(); ph = m_phase(); mfv = m_mf();
    @(posedge dclk);
    oop = e && m_al && (cfg_mode != 2'd0) && (ph != P - 1);
    if (oop) oop_total++;
    if (err_clr) begin m_err = 0; m_cnt = 0; end
    if (oop) begin m_err = 1; if (m_cnt < 255) m_cnt++; end
    k++;
    raw.push_back(sysref);
    if (cfg_mode == 2'd0) begin
      m_stage = 0; m_al = 0;
    end else begin
      case (m_stage)
        0: m_stage = 1;
        1: if (e) begin load_k = k; mf_base = 0; m_al = 1; m_stage = 2; end
        default: begin
          if (cfg_mode == 2'd1 && cfg_arm) m_stage = 1;
          else if (cfg_mode == 2'd2 && e) begin load_k = k; mf_base = (mfv + 1) % 256; end
        end
      endcase
    end
    #1;
  endtask

  // Raise SYSREF so that its edge is detected while the phase equals tgt;
  // optionally pulse cfg_arm / err_clr in that detection cycle.
  task automatic pulse_at(int tgt, bit with_arm, bit with_clr);
    int w;
    sysref = 1'b0;
    repeat (S + 2) tick();
    w = (tgt - 1 - S + 2 * P) % P;
    for (int i = 0; i < 2 * P && o_lmfc_phase != 4'(w); i++) tick();
    checks++;
    if (o_lmfc_phase != 4'(w)) begin
      errors++;
      $display("FAIL pulse_wait phase=%0d required=%0d", o_lmfc_phase, w);
    end
    sysref = 1'b1;
    repeat (S + 1) tick();
    cfg_arm = with_arm;
    err_clr = with_clr;
    tick();
    cfg_arm = 1'b0;
    err_clr = 1'b0;
    sysref  = 1'b0;
    repeat (S + 2) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; sysref = 1'b1; cfg_mode = 2'd1;
    #3;
    checks++;
    if (act_vec !== 23'd0) begin
      errors++; $display("FAIL reset_state got=%h required=0", act_vec);
    end
    model_reset();
    @(negedge dclk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_release cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (o_aligned !== 1'b0) begin
      errors++; $display("FAIL reset_no_edge aligned=%b required=0", o_aligned);
    end
  endtask

  task automatic test_align_mode1();
    int n, pulses;
    sysref = 1'b0;
    repeat (5 + $urandom_range(0, 15)) tick();
    sysref = 1'b1;
    n = 0;
    while (o_aligned !== 1'b1 && n < 20) begin
      tick(); n++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL align_track cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (n != LAT || o_lmfc_phase !== 4'd0 || o_lmfc !== 1'b1) begin
      errors++; $display("FAIL align_latency got=%0d/phase %0d required=%0d/phase 0", n, o_lmfc_phase, LAT);
    end
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) sysref = 1'b0;
      tick();
      pulses += int'(o_lmfc);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL align_run cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL lmfc_period pulses=%0d required=4", pulses);
    end
  endtask

  task automatic test_mode2();
    cfg_mode = 2'd2;
    pulse_at(7, 1'b0, 1'b0);
    checks++;
    if (o_lmfc_phase !== 4'(S + 2) || o_sysref_err !== 1'b1 || o_err_cnt !== 8'd1) begin
      errors++; $display("FAIL mode2_realign phase=%0d err=%b cnt=%0d required=%0d/1/1",
                         o_lmfc_phase, o_sysref_err, o_err_cnt, S + 2);
    end
    pulse_at(15, 1'b0, 1'b0);
    checks++;
    if (o_lmfc_phase !== 4'((15 + 1 + S + 2) % P) || o_err_cnt !== 8'd1 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL mode2_inphase got=%h required=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_mode3_sat();
    int start, guard;
    cfg_mode = 2'd3;
    pulse_at(3, 1'b0, 1'b1);
    checks++;
    if (o_err_cnt !== 8'd1 || o_sysref_err !== 1'b1) begin
      errors++; $display("FAIL clr_collision cnt=%0d err=%b required=1/1", o_err_cnt, o_sysref_err);
    end
    start = oop_total;
    guard = 0;
    while (oop_total - start < 300 && guard < 20000) begin
      sysref = 1'($urandom_range(0, 1));
      tick(); guard++;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL mode3_track cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    sysref = 1'b0;
    checks++;
    if (o_err_cnt !== 8'd255 || oop_total - start < 300) begin
      errors++; $display("FAIL err_saturate cnt=%0d required=255", o_err_cnt);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (o_err_cnt !== 8'd0 || o_sysref_err !== 1'b0 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL err_clear cnt=%0d err=%b required=0/0", o_err_cnt, o_sysref_err);
    end
  endtask

  task automatic test_rearm();
    cfg_mode = 2'd1;
    tick();
    cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
    pulse_at(4, 1'b0, 1'b0);
    checks++;
    if (o_lmfc_phase !== 4'(S + 2) || o_err_cnt !== 8'd1 || o_aligned !== 1'b1) begin
      errors++; $display("FAIL rearm_realign phase=%0d cnt=%0d required=%0d/1", o_lmfc_phase, o_err_cnt, S + 2);
    end
    pulse_at(9, 1'b1, 1'b0);
    checks++;
    if (o_lmfc_phase !== 4'((9 + 1 + S + 2) % P) || o_err_cnt !== 8'd2) begin
      errors++; $display("FAIL arm_edge_same_cycle phase=%0d cnt=%0d required=%0d/2",
                         o_lmfc_phase, o_err_cnt, (12 + S) % P);
    end
    pulse_at(5, 1'b0, 1'b0);
    checks++;
    if (o_lmfc_phase !== 4'(S + 2) || o_err_cnt !== 8'd3 || act_vec !== exp_vec()) begin
      errors++; $display("FAIL arm_next_edge got=%h required=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_mode0();
    cfg_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL mode0_run cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    checks++;
    if (o_aligned !== 1'b0 || o_err_cnt !== 8'd3 || o_sysref_err !== 1'b1) begin
      errors++; $display("FAIL mode0_state aligned=%b cnt=%0d required=0/3", o_aligned, o_err_cnt);
    end
  endtask

  task automatic test_async_reset();
    int n;
    cfg_mode = 2'd1;
    repeat (3) tick();
    pulse_at(6, 1'b0, 1'b0);
    repeat (5) tick();
    sysref = 1'b1;
    @(negedge dclk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== 23'd0) begin
      errors++; $display("FAIL async_reset got=%h required=0", act_vec);
    end
    model_reset();
    @(negedge dclk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec() || o_aligned !== 1'b0) begin
        errors++; $display("FAIL post_reset cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    sysref = 1'b0;
    repeat (3) tick();
    sysref = 1'b1;
    n = 0;
    while (o_aligned !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != LAT || act_vec !== exp_vec()) begin
      errors++; $display("FAIL fresh_edge latency=%0d got=%h required=%0d/%h", n, act_vec, LAT, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg_mode = 2'($urandom_range(0, 3));
      cfg_arm = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) sysref = ~sysref;
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h required=%h", k, act_vec, exp_vec());
      end
    end
    cfg_arm = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    oop_total = 0;
    model_reset();
    test_reset();
    test_align_mode1();
    test_mode2();
    test_mode3_sat();
    test_rearm();
    test_mode0();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
